// File: rtl/truth_table_scanner_if.sv
// Scanner bus: stimulus/capture signals between a scan controller and the function block under test.
// Latency: none (wires only).
// Backpressure: none; start is a level request qualified by busy.
// Ports (slave = scanner side):
//   start, down : scan request and scan order (into the scanner)
//   f           : function block result, combinational from w (into the scanner)
//   w           : select code driven to the function block
//   busy, done  : scan in progress / one-cycle completion pulse
//   table_out   : captured truth table, bit k = f at w == k
//   ones        : population count of table_out
interface truth_table_scanner_if #(
    parameter int WIDTH = 3
);
    logic                    start;
    logic                    down;
    logic                    f;
    logic [WIDTH-1:0]        w;
    logic                    busy;
    logic                    done;
    logic [(1<<WIDTH)-1:0]   table_out;
    logic [WIDTH:0]          ones;

    modport master (
        output start, down, f,
        input  w, busy, done, table_out, ones
    );

    modport slave (
        input  start, down, f,
        output w, busy, done, table_out, ones
    );
endinterface

// File: rtl/truth_table_scanner.sv
// Walks select code w over every index, samples f per index into a truth table and counts ones.
// Latency: each index holds SETTLE+1 cycles; done pulses 2^WIDTH*(SETTLE+1) edges after start accept.
// Backpressure: start ignored while busy; a start during the done cycle is accepted (no dead cycle).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; clears all state, discarding any partial table
//   bus   : scanner side of truth_table_scanner_if (start/down/f in, w/busy/done/table_out/ones out)
module truth_table_scanner #(
    parameter int WIDTH  = 3,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    truth_table_scanner_if.slave   bus
);
    localparam int               ENTRIES    = 1 << WIDTH;
    localparam logic [WIDTH-1:0] LAST_UP    = WIDTH'(ENTRIES - 1);
    localparam logic [3:0]       SETTLE_CNT = 4'(SETTLE);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t     state;
    logic       down_q;
    logic [3:0] hold_cnt;
    logic       last_idx;

    // Last index depends on the scan order latched at start; w never wraps.
    assign last_idx = down_q ? (bus.w == '0) : (bus.w == LAST_UP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            down_q        <= 1'b0;
            hold_cnt      <= 4'd0;
            bus.w         <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.table_out <= '0;
            bus.ones      <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    bus.w <= '0;
                    if (bus.start) begin
                        down_q        <= bus.down;
                        bus.table_out <= '0;
                        bus.ones      <= '0;
                        bus.w         <= bus.down ? LAST_UP : '0;
                        hold_cnt      <= SETTLE_CNT;
                        bus.busy      <= 1'b1;
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt != 4'd0) begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end else begin
                        // Final edge of this index's window: capture f for the current w.
                        bus.table_out[bus.w] <= bus.f;
                        bus.ones             <= bus.ones + {{WIDTH{1'b0}}, bus.f};
                        if (last_idx) begin
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            bus.w    <= '0;
                            state    <= IDLE;
                        end else begin
                            bus.w    <= down_q ? (bus.w - WIDTH'(1)) : (bus.w + WIDTH'(1));
                            hold_cnt <= SETTLE_CNT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequential stimulus and capture stage that wraps a combinational select-decoder function block.
- Drives the block's select code w through every index 0..2^WIDTH-1, then samples the block's single-bit result f at each index.
- Assembles the sampled values into a truth-table register and reports a count of ones.
- Sits directly upstream (w) and downstream (f) of the 3-to-8 decoder-based function block; used for self-test and characterisation of that block.

Parameters:
- WIDTH, 3, width of select code w; the table has 2^WIDTH entries.
- SETTLE, 1, extra hold cycles per index before f is sampled (legal range 0..15).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  scan request; accepted only when busy=0.
- down  input  1  scan order, sampled with an accepted start: 0 = ascending 0..2^WIDTH-1, 1 = descending 2^WIDTH-1..0.
- f  input  1  result from the function block, combinational from w.
- w  output  WIDTH  registered select code fed to the function block.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse after the last index is sampled.
- table_out  output  2^WIDTH  captured truth table; bit k = f when w == k.
- ones  output  WIDTH+1  number of ones in table_out.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. On reset assertion, immediately: w=0, busy=0, done=0, table_out=0, ones=0, FSM=IDLE, hold counter=0. This applies mid-scan too; a partial table is discarded.
- FSM states:
  - IDLE: busy=0, w=0. On start=1, at the accepting edge:
    - latch down;
    - clear table_out and ones;
    - load w with the first index (0 if ascending, 2^WIDTH-1 if descending);
    - load hold counter with SETTLE;
    - set busy=1; go to HOLD.
  - HOLD: w stable. If hold counter != 0, decrement it and stay. If hold counter == 0, go to SAMPLE behaviour on this same edge:
    - table_out[w] <= f; ones <= ones + f;
    - if w is not the last index: step w by +1 or -1, reload hold counter with SETTLE, stay in HOLD;
    - if w is the last index: busy<=0, done<=1, w<=0, go to IDLE.
- Latency:
  - Each index occupies exactly SETTLE+1 cycles; f is sampled on the final edge of that window.
  - done rises 2^WIDTH*(SETTLE+1) edges after the start-accept edge (WIDTH=3, SETTLE=1: 16 edges).
- done: high for exactly one cycle, which is the first IDLE cycle. start seen during that cycle is accepted (back-to-back scans, no dead cycle).
- start while busy=1 is ignored; down changes while busy are ignored.
- table_out and ones hold their final values after done until the next start is accepted.
- w never leaves 0..2^WIDTH-1; there is no wrap-around during a scan.
- Arithmetic: ones never overflows, since at most 2^WIDTH fits in WIDTH+1 bits.

Test Plan:
- Ascending scan, SETTLE=1, function block f = w∈{3,5,6,7}: pulse start -> w sequence 0,0,1,1,…,7,7; done at edge 16; table_out=8'hE8, ones=4, w=0 afterwards.
- Same setup with down=1 -> w sequence 7,7,6,6,…,0,0; table_out=8'hE8, ones=4, done at edge 16.
- SETTLE=0 with f tied to 1 -> w advances every cycle; done at edge 8; table_out=8'hFF, ones=8. Repeat with f tied to 0 -> table_out=8'h00, ones=0.
- Start pulsed mid-scan at edge 5 -> ignored; sequence and done timing unchanged. Start held high continuously -> new scan accepted in the done cycle; table cleared and w=0 on the next edge.
- Reset asserted asynchronously at edge 9 of a scan (between clock edges) -> outputs clear immediately; after release, no done occurs until a new start.
- Stale-table check: after a completed scan (table_out=8'hE8), run a second scan with f tied to 0 -> table_out=8'h00, no stale bits.
